vector_mem_unit: RTL and testbench
==================================

# vector_mem_unit

Memory-stage load/store engine of the vectorial CPU. Accepts one vector (R lanes of N bits) or scalar memory request per instruction and serializes it into lane-wide beats over a single ack-handshaked data-memory port. Gathers load data into the full-width ReadDataM bus consumed by the MEM/WB segment, and stalls the pipeline while beats are outstanding.

## Interface
- N, 8, lane width in bits
- R, 6, lanes per vector
- A, 16, memory address width (lane-granular addresses)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, asynchronous, active-high
- ReqValidM  in  1  memory instruction present in MEM this cycle
- MemWriteM  in  1  1 = store, 0 = load; sampled at accept
- LDSFlagM  in  1  1 = scalar access (lane 0 only), 0 = full vector; sampled at accept
- AddrM  in  A  base address; sampled at accept
- WriteDataM  in  R×N  store data, lane i = [i]; captured at accept
- ReadDataM  out  R×N  gathered load data
- StallM  out  1  freeze IF/ID/EX/MEM segments
- DoneM  out  1  one-cycle pulse: access complete
- mem_req  out  1  beat request
- mem_we  out  1  beat is a write
- mem_addr  out  A  beat address
- mem_wdata  out  N  beat write data
- mem_rdata  in  N  beat read data, valid with mem_ack
- mem_ack  in  1  beat accepted/completed

## Operation
- States: IDLE, BEAT, DONE.
- IDLE: on ReqValidM=1, capture MemWriteM, LDSFlagM, AddrM, WriteDataM; lane←0; last←(LDSFlagM ? 0 : R−1); →BEAT.
- BEAT: mem_req=1, mem_we=captured write, mem_addr=base+lane (modulo 2^A, wraps silently), mem_wdata=captured lane data. Held stable until mem_ack=1 sampled. On ack: if load, ReadDataM[lane]←mem_rdata; if lane==last →DONE else lane←lane+1.
- DONE: DoneM=1 for exactly this cycle; →IDLE unconditionally.
- Load start clears ReadDataM to 0 at accept; scalar load therefore leaves lanes 1..R−1 zero. Store leaves ReadDataM unchanged.
- ReadDataM holds its value from DONE until the next accepted load.
- StallM = (state==BEAT) | (state==IDLE & ReqValidM). Deasserted in DONE so MEM/WB captures ReadDataM on the following negedge.
- mem_ack in IDLE or DONE ignored. ReqValidM in BEAT/DONE ignored (pipeline frozen / instruction retiring).
- Reset (any time, incl. mid-burst): state→IDLE, lane→0, all captured fields→0; outputs immediately: ReadDataM=0, StallM=0, DoneM=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. An in-flight beat is abandoned; the memory must drop it.

## Timing
- Accept cycle c0; first beat issued in c1.
- Each beat ≥1 cycle; with mem_ack tied high: vector load/store = R+2 cycles (accept, R beats, DONE), scalar = 3 cycles.
- ack stall of k cycles on a beat adds exactly k cycles.
- Back-to-back: new request accepted earliest in the cycle after DONE.
- mem_* outputs are registered-state driven: no combinational path mem_ack→mem_req/mem_addr.

## Structure
- Package vmem_pkg: state enum (IDLE, BEAT, DONE), lane-index typedef of width $clog2(R).
- Single module; no sub-module. Beat datapath (address adder, lane mux) inline.

## Test plan
- Vector load, AddrM=0x0010, mem_ack always 1, memory word at k = k[7:0] -> beats at 0x10..0x15, ReadDataM = {0x15,0x14,0x13,0x12,0x11,0x10}, DoneM in cycle 7, StallM high cycles 0–6.
- Vector store, WriteDataM lanes {6,5,4,3,2,1}, ack delayed 2 cycles on lane 3 -> mem_we=1, lane data 1..6 at consecutive addresses, total 10 cycles, mem_addr/mem_wdata stable while waiting.
- Scalar load AddrM=0x0040, mem[0x40]=0xAB -> single beat, ReadDataM = {0,0,0,0,0,0xAB}, DoneM in cycle 2.
- Wrap: vector load AddrM=0xFFFE -> beat addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002, 0x0003.
- Reset asserted during lane 2 of vector load -> mem_req, StallM, ReadDataM drop to 0 immediately; after release, fresh load completes normally.
- Spurious mem_ack in IDLE, and ReqValidM held high through DONE -> no state change from ack; second request accepted only in cycle after DoneM.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared types and default geometry for the vector memory-stage load/store engine.
package vmem_pkg;

  localparam int VMEM_N = 8;
  localparam int VMEM_R = 6;
  localparam int VMEM_A = 16;
  localparam int LANE_W = (VMEM_R > 1) ? $clog2(VMEM_R) : 1;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DONE
  } state_t;

endpackage

// File: rtl/vector_mem_unit_if.sv
// Lane-wide, ack-handshaked data-memory port between the load/store engine and memory.
interface vector_mem_unit_if #(
  parameter int N = 8,
  parameter int A = 16
);
  logic         mem_req;
  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/vector_mem_unit.sv
// MEM-stage engine: serializes one vector/scalar access into lane beats on the memory
// port, gathers load data into ReadDataM and stalls the pipeline while beats are pending.
module vector_mem_unit
  import vmem_pkg::*;
#(
  parameter int N = VMEM_N,
  parameter int R = VMEM_R,
  parameter int A = VMEM_A
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ReqValidM,
  input  logic             MemWriteM,
  input  logic             LDSFlagM,
  input  logic [A-1:0]     AddrM,
  input  logic [R*N-1:0]   WriteDataM,
  output logic [R*N-1:0]   ReadDataM,
  output logic             StallM,
  output logic             DoneM,
  vector_mem_unit_if.master mem
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;

  state_t           state_q, state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [LW-1:0]    last_q, last_d;
  logic             we_q, we_d;
  logic [A-1:0]     base_q, base_d;
  logic [R*N-1:0]   wdata_q, wdata_d;
  logic [R*N-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    last_d  = last_q;
    we_d    = we_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (ReqValidM) begin
          we_d    = MemWriteM;
          base_d  = AddrM;
          wdata_d = WriteDataM;
          lane_d  = '0;
          last_d  = LDSFlagM ? '0 : LW'(R - 1);
          if (!MemWriteM) rdata_d = '0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (mem.mem_ack) begin
          if (!we_q) rdata_d[int'(lane_q)*N +: N] = mem.mem_rdata;
          if (lane_q == last_q) state_d = DONE;
          else                  lane_d  = lane_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-port outputs depend only on registered state, never on mem_ack.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state_q == BEAT) begin
      mem.mem_req   = 1'b1;
      mem.mem_we    = we_q;
      mem.mem_addr  = base_q + A'(lane_q);
      mem.mem_wdata = wdata_q[int'(lane_q)*N +: N];
    end
  end

  assign ReadDataM = rdata_q;
  assign DoneM     = (state_q == DONE);
  assign StallM    = (state_q == BEAT) | ((state_q == IDLE) & ReqValidM);

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench for vector_mem_unit: table vectors, corner sequences and random traffic.
module tb_vector_mem_unit;
  localparam int N = 8;
  localparam int R = 6;
  localparam int A = 16;

  logic             clk;
  logic             reset;
  logic             ReqValidM;
  logic             MemWriteM;
  logic             LDSFlagM;
  logic [A-1:0]     AddrM;
  logic [R*N-1:0]   WriteDataM;
  logic [R*N-1:0]   ReadDataM;
  logic             StallM;
  logic             DoneM;

  vector_mem_unit_if #(.N(N), .A(A)) mif ();

  vector_mem_unit #(.N(N), .R(R), .A(A)) dut (
    .clk        (clk),
    .reset      (reset),
    .ReqValidM  (ReqValidM),
    .MemWriteM  (MemWriteM),
    .LDSFlagM   (LDSFlagM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .DoneM      (DoneM),
    .mem        (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem_arr [0:65535];
  logic [47:0] rd_model;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic        we;
    logic        lds;
    logic [15:0] addr;
    logic [47:0] wd;
    int          dly_lane;
    int          dly_k;
    int          exp_done;
    logic [47:0] exp_rd;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected gathered data for a load: lanes read at base+i (16-bit wrap), rest zero.
  function automatic logic [47:0] model_load(input logic lds, input logic [15:0] addr);
    logic [47:0] r;
    logic [15:0] a;
    int cnt;
    r = '0;
    cnt = lds ? 1 : R;
    for (int i = 0; i < cnt; i++) begin
      a = addr + 16'(i);
      r[i*8 +: 8] = mem_arr[a];
    end
    return r;
  endfunction

  // Starts in an IDLE cycle at negedge; ends at negedge of the IDLE cycle after DONE.
  task automatic run_txn(input string name, input logic we, input logic lds,
                         input logic [15:0] addr, input logic [47:0] wd,
                         input int dly_lane, input int dly_k, input bit hold,
                         input int exp_done, input logic [47:0] exp_rd);
    int cyc, b, waited, cnt;
    bit fin;
    logic [15:0] ea;
    cnt = lds ? 1 : R;
    ReqValidM  = 1'b1;
    MemWriteM  = we;
    LDSFlagM   = lds;
    AddrM      = addr;
    WriteDataM = wd;
    mif.mem_ack   = 1'($urandom);
    mif.mem_rdata = 8'($urandom);
    #1;
    chk({name, " accept StallM"}, 64'(StallM), 64'd1);
    cyc = 0; b = 0; waited = 0; fin = 1'b0;
    for (int g = 0; g < 64 && !fin; g++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (!hold) begin
        ReqValidM  = 1'b0;
        MemWriteM  = 1'($urandom);
        LDSFlagM   = 1'($urandom);
        AddrM      = 16'($urandom);
        WriteDataM = 48'({$urandom(), $urandom()});
      end
      if (b < cnt) begin
        ea = addr + 16'(b);
        chk({name, " mem_req"}, 64'(mif.mem_req), 64'd1);
        chk({name, " mem_we"}, 64'(mif.mem_we), 64'(we));
        chk({name, " mem_addr"}, 64'(mif.mem_addr), 64'(ea));
        if (we) chk({name, " mem_wdata"}, 64'(mif.mem_wdata), 64'(wd[b*8 +: 8]));
        chk({name, " beat StallM"}, 64'(StallM), 64'd1);
        chk({name, " beat DoneM"}, 64'(DoneM), 64'd0);
        if (b == dly_lane && waited < dly_k) begin
          mif.mem_ack   = 1'b0;
          mif.mem_rdata = 8'($urandom);
          waited++;
        end else begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = mem_arr[ea];
          if (we) mem_arr[ea] = mif.mem_wdata;
          b++;
        end
      end else begin
        mif.mem_ack   = 1'($urandom);
        mif.mem_rdata = 8'($urandom);
        chk({name, " done cycle"}, 64'(cyc), 64'(exp_done));
        chk({name, " DoneM"}, 64'(DoneM), 64'd1);
        chk({name, " done mem_req"}, 64'(mif.mem_req), 64'd0);
        chk({name, " done StallM"}, 64'(StallM), 64'd0);
        chk({name, " ReadDataM"}, 64'(ReadDataM), 64'(exp_rd));
        fin = 1'b1;
      end
    end
    if (!fin) chk({name, " timeout"}, 64'd0, 64'd1);
    @(posedge clk); @(negedge clk);
    if (!hold) mif.mem_ack = 1'($urandom);
    chk({name, " idle DoneM"}, 64'(DoneM), 64'd0);
    chk({name, " idle StallM"}, 64'(StallM), 64'(hold));
    chk({name, " hold ReadDataM"}, 64'(ReadDataM), 64'(exp_rd));
    if (we) begin
      for (int i = 0; i < cnt; i++) begin
        ea = addr + 16'(i);
        chk({name, " stored"}, 64'(mem_arr[ea]), 64'(wd[i*8 +: 8]));
      end
    end
  endtask

  initial begin
    logic        we, lds;
    logic [15:0] addr;
    logic [47:0] wd, exp_rd;
    int          dl, dk, cnt;

    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 65536; k++) mem_arr[k] = k[7:0];
    mem_arr[16'h0040] = 8'hAB;

    reset = 1'b1; ReqValidM = 1'b0; MemWriteM = 1'b0; LDSFlagM = 1'b0;
    AddrM = '0; WriteDataM = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset ReadDataM", 64'(ReadDataM), 64'd0);
    chk("reset StallM", 64'(StallM), 64'd0);
    chk("reset DoneM", 64'(DoneM), 64'd0);
    chk("reset mem_req", 64'(mif.mem_req), 64'd0);
    chk("reset mem_addr", 64'(mif.mem_addr), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    tbl[0] = '{1'b0, 1'b0, 16'h0010, 48'h0,            0, 0, 7,  48'h151413121110};
    tbl[1] = '{1'b1, 1'b0, 16'h0100, 48'h060504030201, 3, 2, 9,  48'h151413121110};
    tbl[2] = '{1'b0, 1'b1, 16'h0040, 48'h0,            0, 0, 2,  48'h0000000000AB};
    tbl[3] = '{1'b0, 1'b0, 16'hFFFE, 48'h0,            0, 0, 7,  48'h03020100FFFE};
    tbl[4] = '{1'b1, 1'b1, 16'h0200, 48'hAAAAAAAAAA5A, 0, 0, 2,  48'h03020100FFFE};
    tbl[5] = '{1'b0, 1'b0, 16'h0100, 48'h0,            0, 3, 10, 48'h060504030201};
    for (int t = 0; t < 6; t++)
      run_txn($sformatf("tbl%0d", t), tbl[t].we, tbl[t].lds, tbl[t].addr, tbl[t].wd,
              tbl[t].dly_lane, tbl[t].dly_k, 1'b0, tbl[t].exp_done, tbl[t].exp_rd);
    chk("scalar store lane0 only", 64'(mem_arr[16'h0201]), 64'h01);

    // Reset in the middle of a vector load, during lane 2.
    ReqValidM = 1'b1; MemWriteM = 1'b0; LDSFlagM = 1'b0; AddrM = 16'h0320;
    mif.mem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    ReqValidM = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mif.mem_rdata = mem_arr[mif.mem_addr];
      @(posedge clk); @(negedge clk);
    end
    chk("midrst lane2 addr", 64'(mif.mem_addr), 64'h0322);
    chk("midrst partial data", 64'(ReadDataM), 64'h2120);
    mif.mem_ack = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst mem_req", 64'(mif.mem_req), 64'd0);
    chk("midrst StallM", 64'(StallM), 64'd0);
    chk("midrst ReadDataM", 64'(ReadDataM), 64'd0);
    chk("midrst mem_addr", 64'(mif.mem_addr), 64'd0);
    chk("midrst mem_we", 64'(mif.mem_we), 64'd0);
    chk("midrst DoneM", 64'(DoneM), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_txn("post-reset load", 1'b0, 1'b0, 16'h0320, 48'h0, 0, 0, 1'b0, 7,
            model_load(1'b0, 16'h0320));

    // Spurious acks while idle must not start anything.
    ReqValidM = 1'b0;
    mif.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("spurious ack mem_req", 64'(mif.mem_req), 64'd0);
      chk("spurious ack StallM", 64'(StallM), 64'd0);
      chk("spurious ack DoneM", 64'(DoneM), 64'd0);
    end

    // Request held through DONE: next accept only in the cycle after DoneM.
    run_txn("hold first", 1'b0, 1'b1, 16'h0040, 48'h0, 0, 0, 1'b1, 2, 48'hAB);
    run_txn("hold second", 1'b0, 1'b1, 16'h0040, 48'h0, 0, 0, 1'b0, 2, 48'hAB);
    rd_model = 48'hAB;

    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom);
      lds  = ($urandom_range(0, 3) == 0);
      addr = 16'($urandom);
      wd   = 48'({$urandom(), $urandom()});
      dl   = int'($urandom_range(0, R - 1));
      dk   = int'($urandom_range(0, 3));
      cnt  = lds ? 1 : R;
      exp_rd = we ? rd_model : model_load(lds, addr);
      run_txn($sformatf("rand%0d", t), we, lds, addr, wd, dl, dk, 1'b0,
              cnt + 1 + ((dl < cnt) ? dk : 0), exp_rd);
      rd_model = exp_rd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
